// File: rtl/mag_window_detector.sv
// Sliding-window average, clearable peak hold and hysteresis detector
// for the 8-bit magnitude stream.
module mag_window_detector #(
    parameter int LOG2_WIN = 3,
    parameter int HOLDOFF  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] mag_in,
    input  logic       mag_valid,
    input  logic [7:0] thr_hi,
    input  logic [7:0] thr_lo,
    input  logic       peak_clr,
    output logic [7:0] avg_out,
    output logic [7:0] peak_out,
    output logic       fill_done,
    output logic       detect,
    output logic       event_pulse,
    output logic [1:0] state_dbg
);

    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = 8 + LOG2_WIN;
    localparam int HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 2) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BELOW = 2'd1,
        ST_ABOVE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state;
    logic [7:0]          win_buf [WIN];
    logic [LOG2_WIN-1:0] wp;
    logic [SW-1:0]       sum;
    logic [SW-1:0]       nsum;
    logic [LOG2_WIN:0]   fill_cnt;
    logic [HW-1:0]       hcnt;
    logic [HW-1:0]       hcnt_inc;
    logic [7:0]          navg;
    logic [7:0]          eff_lo;
    logic                fill_now;

    // mag_valid is a one-way strobe: every cycle it is high the sample is
    // consumed on that edge; there is no ready and no backpressure.
    always_comb begin
        nsum     = sum + SW'(mag_in) - SW'(win_buf[wp]);
        navg     = nsum[SW-1:LOG2_WIN];
        eff_lo   = (thr_lo < thr_hi) ? thr_lo : thr_hi;
        hcnt_inc = hcnt + HW'(1);
        fill_now = !fill_done && (fill_cnt == (LOG2_WIN+1)'(WIN - 1));
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            for (int i = 0; i < WIN; i++) win_buf[i] <= 8'd0;
            wp          <= '0;
            sum         <= '0;
            fill_cnt    <= '0;
            hcnt        <= '0;
            avg_out     <= 8'd0;
            peak_out    <= 8'd0;
            fill_done   <= 1'b0;
            detect      <= 1'b0;
            event_pulse <= 1'b0;
        end else begin
            event_pulse <= 1'b0;

            // A clear restarts tracking from the current sample, if any.
            if (peak_clr)
                peak_out <= mag_valid ? mag_in : 8'd0;
            else if (mag_valid && (mag_in > peak_out))
                peak_out <= mag_in;

            if (mag_valid) begin
                win_buf[wp] <= mag_in;
                wp          <= wp + LOG2_WIN'(1);
                sum         <= nsum;
                avg_out     <= navg;
                if (!fill_done) fill_cnt <= fill_cnt + (LOG2_WIN+1)'(1);
                if (fill_now) fill_done <= 1'b1;

                case (state)
                    ST_IDLE: begin
                        if (fill_now) begin
                            if (navg >= thr_hi) begin
                                state       <= ST_ABOVE;
                                detect      <= 1'b1;
                                event_pulse <= 1'b1;
                            end else begin
                                state <= ST_BELOW;
                            end
                        end
                    end
                    ST_BELOW: begin
                        if (navg >= thr_hi) begin
                            state       <= ST_ABOVE;
                            detect      <= 1'b1;
                            event_pulse <= 1'b1;
                        end
                    end
                    ST_ABOVE: begin
                        if (navg < eff_lo) begin
                            detect <= 1'b0;
                            hcnt   <= '0;
                            state  <= (HOLDOFF == 0) ? ST_BELOW : ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        hcnt <= hcnt_inc;
                        if (hcnt_inc == HW'(HOLDOFF)) state <= ST_BELOW;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mag_window_detector.sv
// Directed bench for mag_window_detector: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_mag_window_detector;

    localparam int W = 21;

    logic       clk;
    logic       rst_n;
    logic [7:0] mag_in;
    logic       mag_valid;
    logic [7:0] thr_hi;
    logic [7:0] thr_lo;
    logic       peak_clr;
    logic [7:0] avg_out;
    logic [7:0] peak_out;
    logic       fill_done;
    logic       detect;
    logic       event_pulse;
    logic [1:0] state_dbg;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    int a100 [8] = '{12, 25, 37, 50, 62, 75, 87, 100};
    int a20  [8] = '{90, 80, 70, 60, 50, 40, 30, 20};
    int a255 [8] = '{31, 63, 95, 127, 159, 191, 223, 255};

    mag_window_detector #(.LOG2_WIN(3), .HOLDOFF(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mag_in      (mag_in),
        .mag_valid   (mag_valid),
        .thr_hi      (thr_hi),
        .thr_lo      (thr_lo),
        .peak_clr    (peak_clr),
        .avg_out     (avg_out),
        .peak_out    (peak_out),
        .fill_done   (fill_done),
        .detect      (detect),
        .event_pulse (event_pulse),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue=%0d required=0", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pack(input int a, input int p, input logic f,
                                          input logic d, input logic e, input int s);
        return {8'(a), 8'(p), f, d, e, 2'(s)};
    endfunction

    // driver tasks
    task automatic step(input logic v, input int m, input logic clr,
                        input int ea, input int ep, input logic ef,
                        input logic ed, input logic ee, input int es);
        @(negedge clk);
        rst_n     = 1'b1;
        mag_valid = v;
        mag_in    = 8'(m);
        peak_clr  = clr;
        @(posedge clk);
        #1;
        exp_q.push_back(pack(ea, ep, ef, ed, ee, es));
    endtask

    task automatic rst_step();
        @(negedge clk);
        rst_n     = 1'b0;
        mag_valid = 1'b1;
        mag_in    = 8'($urandom_range(0, 255));
        peak_clr  = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(pack(0, 0, 1'b0, 1'b0, 1'b0, 0));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (avg_out !== e[20:13]) begin
                errors++;
                $display("FAIL avg_out: got %0d expected %0d at %0t", avg_out, e[20:13], $time);
            end
            checks++;
            if (peak_out !== e[12:5]) begin
                errors++;
                $display("FAIL peak_out: got %0d expected %0d at %0t", peak_out, e[12:5], $time);
            end
            checks++;
            if (fill_done !== e[4]) begin
                errors++;
                $display("FAIL fill_done: got %0b expected %0b at %0t", fill_done, e[4], $time);
            end
            checks++;
            if (detect !== e[3]) begin
                errors++;
                $display("FAIL detect: got %0b expected %0b at %0t", detect, e[3], $time);
            end
            checks++;
            if (event_pulse !== e[2]) begin
                errors++;
                $display("FAIL event_pulse: got %0b expected %0b at %0t", event_pulse, e[2], $time);
            end
            checks++;
            if (state_dbg !== e[1:0]) begin
                errors++;
                $display("FAIL state: got %0d expected %0d at %0t", state_dbg, e[1:0], $time);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        mag_in    = 8'd0;
        mag_valid = 1'b0;
        peak_clr  = 1'b0;
        thr_hi    = 8'd255;
        thr_lo    = 8'd0;

        // reset with live random samples
        repeat (3) rst_step();

        // fill and wrap-around with no detection possible
        for (int i = 0; i < 8; i++)
            step(1'b1, 100, 1'b0, a100[i], 100, i == 7, 1'b0, 1'b0, (i == 7) ? 1 : 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 20, 1'b0, a20[i], 100, 1'b1, 1'b0, 1'b0, 1);
            if (i == 1 || i == 4)
                step(1'b0, $urandom_range(0, 255), 1'b0, a20[i], 100, 1'b1, 1'b0, 1'b0, 1);
        end

        // hysteresis run
        repeat (2) rst_step();
        thr_hi = 8'd80;
        thr_lo = 8'd40;
        for (int i = 0; i < 8; i++)
            step(1'b1, 100, 1'b0, a100[i], 100, i == 7, i == 7, i == 7, (i == 7) ? 2 : 0);
        for (int i = 0; i < 8; i++)
            step(1'b1, 20, 1'b0, a20[i], 100, 1'b1, i < 6, 1'b0, (i < 6) ? 2 : 3);
        step(1'b1, 255, 1'b0, 49,  255, 1'b1, 1'b0, 1'b0, 3);
        step(1'b1, 255, 1'b0, 78,  255, 1'b1, 1'b0, 1'b0, 3);
        step(1'b1, 255, 1'b0, 108, 255, 1'b1, 1'b0, 1'b0, 1);
        step(1'b1, 255, 1'b0, 137, 255, 1'b1, 1'b1, 1'b1, 2);

        // falling threshold is min(thr_lo, thr_hi)
        thr_hi = 8'd100;
        thr_lo = 8'd250;
        step(1'b1, 0, 1'b0, 135, 255, 1'b1, 1'b1, 1'b0, 2);
        step(1'b1, 0, 1'b0, 132, 255, 1'b1, 1'b1, 1'b0, 2);
        thr_hi = 8'd140;
        step(1'b1, 0, 1'b0, 130, 255, 1'b1, 1'b0, 1'b0, 3);
        step(1'b1, 0, 1'b0, 127, 255, 1'b1, 1'b0, 1'b0, 3);

        // reset mid-holdoff, fill must be re-earned
        repeat (2) rst_step();
        thr_hi = 8'd80;
        thr_lo = 8'd40;
        for (int i = 0; i < 8; i++)
            step(1'b1, 255, 1'b0, a255[i], 255, i == 7, i == 7, i == 7, (i == 7) ? 2 : 0);

        // peak hold and clear
        step(1'b0, $urandom_range(0, 255), 1'b1, 255, 0, 1'b1, 1'b1, 1'b0, 2);
        step(1'b1, 5,   1'b0, 223, 5,   1'b1, 1'b1, 1'b0, 2);
        step(1'b1, 200, 1'b0, 216, 200, 1'b1, 1'b1, 1'b0, 2);
        step(1'b1, 7,   1'b0, 185, 200, 1'b1, 1'b1, 1'b0, 2);
        step(1'b1, 3,   1'b1, 154, 3,   1'b1, 1'b1, 1'b0, 2);
        step(1'b0, $urandom_range(0, 255), 1'b1, 154, 0, 1'b1, 1'b1, 1'b0, 2);
        step(1'b0, 0,   1'b0, 154, 0,   1'b1, 1'b1, 1'b0, 2);

        // drain
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: queue=%0d required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
